// File: rtl/inst_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer for the RV32 core: req/ack instruction fetch, one EXEC cycle,
// PC/regfile gating and halt/trap stop. Optional fetch timeout trap enabled by `define FETCH_TIMEOUT_EN.
module inst_seq_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        dec_ebreak,
  input  logic        dec_invalid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        exec_valid,
  output logic        rf_wen_en,
  output logic        halted,
  output logic        trapped,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] instret_r;
  logic [1:0]  cause_r;

  // The wait counter must be able to represent the timeout threshold.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (64'd1 << TMO_W)) begin : g_tmo_check
    $error("inst_seq_ctrl: TMO_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_r;
`endif

  // Sequencer state, PC, latched instruction, retire counter and trap cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      pc_r      <= RESET_PC;
      inst_r    <= 32'd0;
      instret_r <= 32'd0;
      cause_r   <= 2'd0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_r <= '0;
`endif
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_ack) begin
            inst_r  <= imem_rdata;
            state_r <= ST_EXEC;
          end
`ifdef FETCH_TIMEOUT_EN
          // An ack on the expiry cycle wins because it is tested first.
          else if (tmo_cnt_r == TMO_LAST) begin
            cause_r <= 2'd2;
            state_r <= ST_TRAP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
`else
          else begin
            state_r <= ST_FETCH;
          end
`endif
        end
        ST_EXEC: begin
          if (dec_invalid) begin
            cause_r <= 2'd1;
            state_r <= ST_TRAP;
          end else if (dec_ebreak) begin
            instret_r <= instret_r + 32'd1;
            state_r   <= ST_HALT;
          end else begin
            pc_r      <= pc_r + 32'd4;
            instret_r <= instret_r + 32'd1;
            state_r   <= ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_r <= '0;
`endif
          end
        end
        ST_HALT: state_r <= ST_HALT;
        ST_TRAP: state_r <= ST_TRAP;
        default: state_r <= ST_TRAP;
      endcase
    end
  end

  // Outputs are registers or pure state decodes; rf_wen_en also depends on the latched-inst decode.
  always_comb begin
    imem_req   = (state_r == ST_FETCH);
    imem_addr  = pc_r;
    pc         = pc_r;
    inst       = inst_r;
    instret    = instret_r;
    trap_cause = cause_r;
    exec_valid = (state_r == ST_EXEC);
    halted     = (state_r == ST_HALT);
    trapped    = (state_r == ST_TRAP);
    if (state_r == ST_EXEC) begin
      rf_wen_en = ~dec_invalid & ~dec_ebreak;
    end else begin
      rf_wen_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Randomized scoreboard bench for inst_seq_ctrl: a memory driver pushes expected EXEC records,
// a negedge monitor pops and compares them; episode-level checks cover halt, trap, wrap and reset.
module tb_inst_seq_ctrl;
  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
  localparam int          TB_TMO      = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic        dec_ebreak, dec_invalid;
  logic [31:0] pc, inst, instret;
  logic        exec_valid, rf_wen_en, halted, trapped;
  logic [1:0]  trap_cause;

  always #5 clk = ~clk;

  inst_seq_ctrl #(.RESET_PC(TB_RESET_PC), .TIMEOUT_CYCLES(TB_TMO), .TMO_W(8)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dec_ebreak(dec_ebreak), .dec_invalid(dec_invalid), .pc(pc),
    .inst(inst), .exec_valid(exec_valid), .rf_wen_en(rf_wen_en), .halted(halted),
    .trapped(trapped), .trap_cause(trap_cause), .instret(instret)
  );

  function automatic logic is_ebreak(input logic [31:0] w);
    return w == 32'h0010_0073;
  endfunction
  function automatic logic is_invalid(input logic [31:0] w);
    return (w[1:0] != 2'b11) || (w == 32'hFFFF_FFFF);
  endfunction

  // Datapath decode stub driven from the latched instruction.
  assign dec_ebreak  = is_ebreak(inst);
  assign dec_invalid = is_invalid(inst);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [31:0] instret;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] m_pc, m_instret, m_inst;
  logic        m_halt, m_trap;
  logic [1:0]  m_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every EXEC pulse must match the oldest outstanding expected record.
  always @(negedge clk) begin
    if (!rst && exec_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_exec: got exec_valid=1 expected 0 (pc=%h)", pc);
      end else begin
        mon_e = sb_q.pop_front();
        check("exec_pc", pc, mon_e.pc);
        check("exec_inst", inst, mon_e.inst);
        check("exec_wen", {31'd0, rf_wen_en}, {31'd0, mon_e.wen});
        check("exec_instret", instret, mon_e.instret);
      end
    end
  end

  function automatic logic [31:0] gen_word();
    int r;
    logic [31:0] w;
    r = $urandom_range(0, 19);
    if (r < 16) w = {12'($urandom), 5'd0, 3'b000, 5'($urandom), 7'b0010011};
    else if (r < 18) w = 32'h0010_0073;
    else if (r == 18) w = 32'hFFFF_FFFF;
    else w = {30'($urandom), 2'b00};
    return w;
  endfunction

  // Reset is asserted together with an ack to show reset priority over the handshake.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_ack = 1'b0;
    sb_q.delete();
    m_pc = TB_RESET_PC; m_instret = 32'd0; m_inst = 32'd0;
    m_halt = 1'b0; m_trap = 1'b0; m_cause = 2'd0;
    @(negedge clk);
    check("rst_pc", pc, TB_RESET_PC);
    check("rst_inst", inst, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_flags", {28'd0, halted, trapped, trap_cause}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic wait_req(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got imem_req=0 expected 1 within 8 cycles");
    end
  endtask

  task automatic run_episode(input int n);
    logic [31:0] word;
    logic        ok, inv, ebr;
    int          d;
    do_reset();
    for (int i = 0; i < n && !m_halt && !m_trap; i++) begin
      wait_req(ok);
      if (!ok) return;
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        check("wait_req", {31'd0, imem_req}, 32'd1);
        check("wait_addr", imem_addr, m_pc);
        check("wait_inst", inst, m_inst);
        @(negedge clk);
      end
      check("ack_addr", imem_addr, m_pc);
      word = gen_word();
      inv = is_invalid(word);
      ebr = is_ebreak(word);
      imem_ack = 1'b1;
      imem_rdata = word;
      sb_q.push_back(exp_t'{m_pc, word, !inv && !ebr, m_instret});
      m_inst = word;
      if (inv) begin
        m_trap = 1'b1;
        m_cause = 2'd1;
      end else if (ebr) begin
        m_halt = 1'b1;
        m_instret = m_instret + 32'd1;
      end else begin
        m_pc = m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
      end
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("end_pc", pc, m_pc);
    check("end_instret", instret, m_instret);
    check("end_status", {28'd0, halted, trapped, trap_cause}, {28'd0, m_halt, m_trap, m_cause});
    check("end_req", {31'd0, imem_req}, {31'd0, !(m_halt || m_trap)});
    check("end_sb_empty", sb_q.size(), 32'd0);
    if (m_halt || m_trap) begin
      for (int k = 0; k < 3; k++) begin
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
      end
      imem_ack = 1'b0;
      check("stray_pc", pc, m_pc);
      check("stray_inst", inst, m_inst);
      check("stray_instret", instret, m_instret);
      check("stray_status", {30'd0, halted, trapped}, {30'd0, m_halt, m_trap});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int ep = 0; ep < 40; ep++) begin
      run_episode($urandom_range(1, 12));
    end
`ifdef FETCH_TIMEOUT_EN
    do_reset();
    repeat (TB_TMO - 1) @(negedge clk);
    check("tmo_before", {30'd0, imem_req, trapped}, 32'd2);
    @(negedge clk);
    check("tmo_trap", {30'd0, imem_req, trapped}, 32'd1);
    check("tmo_cause", {30'd0, trap_cause}, 32'd2);
    check("tmo_pc", pc, TB_RESET_PC);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
